// File: rtl/monster_hit_controller_pkg.sv
// Shared types and constants for the monster renderer control path:
// screen coordinates, silhouette edge codes, monster box size and life-cycle states.
package monster_hit_controller_pkg;

  localparam int COORD_W = 11;

  typedef logic signed [COORD_W-1:0] coordinate;
  // One extra bit so position arithmetic near the screen edges cannot wrap
  typedef logic signed [COORD_W:0]   coord_ext_t;
  typedef logic [3:0]                edge_code;

  localparam int MONSTERS_X_SIZE = 32;
  localparam int MONSTERS_Y_SIZE = 32;

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    EXPLODING = 2'd1,
    DEAD      = 2'd2
  } monster_state_t;

  // Bit positions inside an edge_code
  localparam int EDGE_LEFT   = 0;
  localparam int EDGE_TOP    = 1;
  localparam int EDGE_RIGHT  = 2;
  localparam int EDGE_BOTTOM = 3;

endpackage

// File: rtl/monster_hit_controller_motion.sv
// Monster position register with horizontal bounce between X_MIN and X_MAX;
// a spawn reloads the start position and the rightward direction.
module monster_hit_controller_motion
  import monster_hit_controller_pkg::*;
#(
  parameter int INIT_X = 64,
  parameter int INIT_Y = 48,
  parameter int X_MIN  = 0,
  parameter int X_MAX  = 607,
  parameter int SPEED  = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      move_i,
  input  logic      spawn_i,
  output coordinate top_left_x_o,
  output coordinate top_left_y_o
);

  coordinate  x_q, x_d;
  coordinate  y_q, y_d;
  logic       dir_right_q, dir_right_d;
  coord_ext_t x_ext_s;

  // Position and direction registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q         <= coordinate'(INIT_X);
      y_q         <= coordinate'(INIT_Y);
      dir_right_q <= 1'b1;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      dir_right_q <= dir_right_d;
    end
  end

  // Bounce logic: clamp to the limit and reverse when the next step would overshoot
  always_comb begin
    x_ext_s     = coord_ext_t'(x_q);
    x_d         = x_q;
    y_d         = y_q;
    dir_right_d = dir_right_q;
    if (spawn_i) begin
      x_d         = coordinate'(INIT_X);
      y_d         = coordinate'(INIT_Y);
      dir_right_d = 1'b1;
    end else if (move_i) begin
      if (dir_right_q) begin
        if (x_ext_s + coord_ext_t'(SPEED) > coord_ext_t'(X_MAX)) begin
          x_d         = coordinate'(X_MAX);
          dir_right_d = 1'b0;
        end else begin
          x_d = coordinate'(x_ext_s + coord_ext_t'(SPEED));
        end
      end else begin
        if (x_ext_s < coord_ext_t'(X_MIN) + coord_ext_t'(SPEED)) begin
          x_d         = coordinate'(X_MIN);
          dir_right_d = 1'b1;
        end else begin
          x_d = coordinate'(x_ext_s - coord_ext_t'(SPEED));
        end
      end
    end else begin
      x_d = x_q;
    end
  end

  assign top_left_x_o = x_q;
  assign top_left_y_o = y_q;

endmodule

// File: rtl/monster_hit_controller.sv
// Per-monster controller: feeds pixel offsets to the silhouette, detects missile
// overlap and runs the ALIVE/EXPLODING/DEAD life cycle.
module monster_hit_controller
  import monster_hit_controller_pkg::*;
#(
  parameter int INIT_X           = 64,
  parameter int INIT_Y           = 48,
  parameter int X_MIN            = 0,
  parameter int X_MAX            = 607,
  parameter int SPEED            = 2,
  parameter int EXPLOSION_FRAMES = 30
) (
  input  logic      clk,
  input  logic      resetN,
  input  logic      startOfFrame,
  input  coordinate pixelX,
  input  coordinate pixelY,
  input  logic      spawn,
  input  logic      monsterDrawingRequest,
  input  edge_code  HitEdgeCode,
  input  logic      missileDrawingRequest,
  output coordinate offsetX,
  output coordinate offsetY,
  output logic      InsideRectangle,
  output logic      monsterIsHit,
  output logic      monsterDead,
  output logic      hitPulse,
  output edge_code  hitEdge,
  output coordinate topLeftX,
  output coordinate topLeftY
);

  localparam int CNT_W = (EXPLOSION_FRAMES > 1) ? $clog2(EXPLOSION_FRAMES) : 1;
  typedef logic [CNT_W-1:0] cnt_t;

  monster_state_t state_q, state_d;
  cnt_t           frame_cnt_q, frame_cnt_d;
  edge_code       hit_edge_q, hit_edge_d;
  logic           collide_s, collide_q;
  logic           hit_pulse_q, hit_pulse_d;
  logic           is_hit_q, is_hit_d;
  logic           dead_q, dead_d;
  logic           take_hit_s, move_s, spawn_s;

  assign collide_s  = monsterDrawingRequest && missileDrawingRequest && (state_q == ALIVE);
  // The edge code lags the drawing request by one cycle, so the hit is taken on collide_q
  assign take_hit_s = collide_q && (state_q == ALIVE);
  assign move_s     = startOfFrame && (state_q == ALIVE) && !collide_q;
  assign spawn_s    = spawn && (state_q == DEAD);

  monster_hit_controller_motion #(
    .INIT_X (INIT_X),
    .INIT_Y (INIT_Y),
    .X_MIN  (X_MIN),
    .X_MAX  (X_MAX),
    .SPEED  (SPEED)
  ) u_motion (
    .clk_i        (clk),
    .rst_ni       (resetN),
    .move_i       (move_s),
    .spawn_i      (spawn_s),
    .top_left_x_o (topLeftX),
    .top_left_y_o (topLeftY)
  );

  assign offsetX = pixelX - topLeftX;
  assign offsetY = pixelY - topLeftY;

  // Box test on signed offsets; a dead monster draws nothing
  always_comb begin
    InsideRectangle = 1'b0;
    if (state_q != DEAD) begin
      InsideRectangle = (offsetX >= coordinate'(0)) && (offsetX < coordinate'(MONSTERS_X_SIZE)) &&
                        (offsetY >= coordinate'(0)) && (offsetY < coordinate'(MONSTERS_Y_SIZE));
    end else begin
      InsideRectangle = 1'b0;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ALIVE;
      frame_cnt_q <= '0;
      hit_edge_q  <= 4'h0;
      collide_q   <= 1'b0;
      hit_pulse_q <= 1'b0;
      is_hit_q    <= 1'b0;
      dead_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      hit_edge_q  <= hit_edge_d;
      collide_q   <= collide_s;
      hit_pulse_q <= hit_pulse_d;
      is_hit_q    <= is_hit_d;
      dead_q      <= dead_d;
    end
  end

  // Life-cycle next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ALIVE: begin
        if (take_hit_s) state_d = EXPLODING;
        else            state_d = ALIVE;
      end
      EXPLODING: begin
        if (startOfFrame && (frame_cnt_q == cnt_t'(EXPLOSION_FRAMES - 1))) state_d = DEAD;
        else                                                               state_d = EXPLODING;
      end
      DEAD: begin
        if (spawn) state_d = ALIVE;
        else       state_d = DEAD;
      end
      default: state_d = ALIVE;
    endcase
  end

  // Next values of the counter and the registered outputs
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    hit_edge_d  = hit_edge_q;
    hit_pulse_d = take_hit_s;
    is_hit_d    = (state_d == EXPLODING);
    dead_d      = (state_d == DEAD);
    if (take_hit_s) begin
      frame_cnt_d = '0;
      hit_edge_d  = HitEdgeCode;
    end else if ((state_q == EXPLODING) && startOfFrame) begin
      frame_cnt_d = frame_cnt_q + cnt_t'(1);
    end else if (spawn_s) begin
      hit_edge_d  = 4'h0;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  assign hitPulse     = hit_pulse_q;
  assign hitEdge      = hit_edge_q;
  assign monsterIsHit = is_hit_q;
  assign monsterDead  = dead_q;

endmodule

// File: tb/tb_monster_hit_controller.sv
// Directed bench for monster_hit_controller with a frame-level reference model
// checked every cycle, plus hand-computed pins on key values.
module tb_monster_hit_controller;
  import monster_hit_controller_pkg::*;

  logic      clk = 1'b0;
  logic      resetN, startOfFrame, spawn, monsterDrawingRequest, missileDrawingRequest;
  coordinate pixelX, pixelY, offsetX, offsetY, topLeftX, topLeftY;
  edge_code  HitEdgeCode, hitEdge;
  logic      InsideRectangle, monsterIsHit, monsterDead, hitPulse;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: 0=alive 1=exploding 2=dead; m_left counts explosion frames still to go
  int m_state, m_x, m_y, m_right, m_left, m_pend, m_edge, m_pulse;

  always #5 clk = ~clk;

  monster_hit_controller dut (
    .clk                   (clk),
    .resetN                (resetN),
    .startOfFrame          (startOfFrame),
    .pixelX                (pixelX),
    .pixelY                (pixelY),
    .spawn                 (spawn),
    .monsterDrawingRequest (monsterDrawingRequest),
    .HitEdgeCode           (HitEdgeCode),
    .missileDrawingRequest (missileDrawingRequest),
    .offsetX               (offsetX),
    .offsetY               (offsetY),
    .InsideRectangle       (InsideRectangle),
    .monsterIsHit          (monsterIsHit),
    .monsterDead           (monsterDead),
    .hitPulse              (hitPulse),
    .hitEdge               (hitEdge),
    .topLeftX              (topLeftX),
    .topLeftY              (topLeftY)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_x = 64; m_y = 48; m_right = 1; m_left = 0;
    m_pend = 0; m_edge = 0; m_pulse = 0;
  endtask

  // Advance one clock; model next state computed from inputs present before the edge
  task automatic tick();
    int s, x, y, r, l, e, p, pend;
    s = m_state; x = m_x; y = m_y; r = m_right; l = m_left; e = m_edge; p = 0; pend = 0;
    if (!resetN) begin
      s = 0; x = 64; y = 48; r = 1; l = 0; e = 0;
    end else begin
      pend = (m_state == 0 && monsterDrawingRequest && missileDrawingRequest) ? 1 : 0;
      if (m_state == 0 && m_pend == 1) begin
        s = 1; e = int'(HitEdgeCode); l = 30; p = 1;
      end else if (m_state == 0 && startOfFrame) begin
        if (r == 1) begin
          if (x + 2 > 607) begin x = 607; r = 0; end
          else x = x + 2;
        end else begin
          if (x < 2) begin x = 0; r = 1; end
          else x = x - 2;
        end
      end else if (m_state == 1 && startOfFrame) begin
        l = l - 1;
        if (l == 0) s = 2;
      end else if (m_state == 2 && spawn) begin
        s = 0; x = 64; y = 48; r = 1; e = 0;
      end
    end
    @(posedge clk);
    #1;
    m_state = s; m_x = x; m_y = y; m_right = r; m_left = l;
    m_edge = e; m_pulse = p; m_pend = pend;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    int ox, oy, ins;
    if (chk_en) begin
      ox  = int'(pixelX) - m_x;
      oy  = int'(pixelY) - m_y;
      ins = (m_state != 2 && ox >= 0 && ox < 32 && oy >= 0 && oy < 32) ? 1 : 0;
      chk("offsetX", int'(offsetX), ox);
      chk("offsetY", int'(offsetY), oy);
      chk("InsideRectangle", int'(InsideRectangle), ins);
      chk("topLeftX", int'(topLeftX), m_x);
      chk("topLeftY", int'(topLeftY), m_y);
      chk("monsterIsHit", int'(monsterIsHit), (m_state == 1) ? 1 : 0);
      chk("monsterDead", int'(monsterDead), (m_state == 2) ? 1 : 0);
      chk("hitPulse", int'(hitPulse), m_pulse);
      chk("hitEdge", int'(hitEdge), m_edge);
    end
  end

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; spawn = 1'b0;
    monsterDrawingRequest = 1'b0; missileDrawingRequest = 1'b0;
    pixelX = 11'sd0; pixelY = 11'sd0; HitEdgeCode = 4'h3;
    model_reset();
    chk_en = 1'b1;
    tick(); tick();
    chk("rst_x", int'(topLeftX), 64);
    chk("rst_y", int'(topLeftY), 48);
    chk("rst_hit", int'(monsterIsHit), 0);
    chk("rst_dead", int'(monsterDead), 0);
    chk("rst_edge", int'(hitEdge), 0);
    resetN = 1'b1;
    tick();

    // Offsets and box test
    pixelX = 11'sd70; pixelY = 11'sd50; #1;
    chk("off70_x", int'(offsetX), 6);
    chk("off70_y", int'(offsetY), 2);
    chk("in70", int'(InsideRectangle), 1);
    pixelX = 11'sd96; #1;
    chk("in96", int'(InsideRectangle), 0);
    pixelX = 11'sd63; #1;
    chk("off63_x", int'(offsetX), -1);
    chk("in63", int'(InsideRectangle), 0);
    tick();

    // Motion and bounce at both limits
    frames(10);
    chk("x_after10", int'(topLeftX), 84);
    frames(261);
    chk("x_606", int'(topLeftX), 606);
    frame();
    chk("x_607", int'(topLeftX), 607);
    frame();
    chk("x_605", int'(topLeftX), 605);
    frames(303);
    chk("x_0", int'(topLeftX), 0);
    frame();
    chk("x_2", int'(topLeftX), 2);

    // Spawn while alive is ignored
    spawn = 1'b1; tick(); spawn = 1'b0; tick();
    chk("spawn_alive_x", int'(topLeftX), 2);

    // Hit with edge code one cycle behind the overlap
    pixelX = 11'sd7; pixelY = 11'sd50;
    monsterDrawingRequest = 1'b1; missileDrawingRequest = 1'b1; HitEdgeCode = 4'h1;
    tick();
    monsterDrawingRequest = 1'b0; missileDrawingRequest = 1'b0; HitEdgeCode = 4'h8;
    tick();
    HitEdgeCode = 4'h2;
    chk("hit_pulse", int'(hitPulse), 1);
    chk("hit_edge", int'(hitEdge), 8);
    chk("hit_is_hit", int'(monsterIsHit), 1);
    tick();
    chk("hit_pulse_once", int'(hitPulse), 0);

    // Explosion lasts 30 frames, no motion meanwhile
    frame();
    chk("expl_nomove", int'(topLeftX), 2);
    frames(28);
    chk("expl29_hit", int'(monsterIsHit), 1);
    chk("expl29_dead", int'(monsterDead), 0);
    frame();
    chk("expl30_dead", int'(monsterDead), 1);
    chk("expl30_hit", int'(monsterIsHit), 0);
    chk("dead_inside", int'(InsideRectangle), 0);
    monsterDrawingRequest = 1'b1; missileDrawingRequest = 1'b1;
    tick();
    monsterDrawingRequest = 1'b0; missileDrawingRequest = 1'b0;
    tick(); tick();
    chk("dead_nopulse", int'(hitPulse), 0);
    chk("dead_edge", int'(hitEdge), 8);

    // Respawn from dead
    spawn = 1'b1; tick(); spawn = 1'b0;
    chk("spawn_x", int'(topLeftX), 64);
    chk("spawn_y", int'(topLeftY), 48);
    chk("spawn_edge", int'(hitEdge), 0);
    chk("spawn_dead", int'(monsterDead), 0);
    tick();

    // Hit coinciding with start of frame: no move, counter starts from zero
    pixelX = 11'sd70; pixelY = 11'sd50;
    monsterDrawingRequest = 1'b1; missileDrawingRequest = 1'b1;
    tick();
    monsterDrawingRequest = 1'b0; missileDrawingRequest = 1'b0;
    startOfFrame = 1'b1; HitEdgeCode = 4'h4;
    tick();
    startOfFrame = 1'b0; HitEdgeCode = 4'h3;
    chk("coinc_x", int'(topLeftX), 64);
    chk("coinc_hit", int'(monsterIsHit), 1);
    chk("coinc_edge", int'(hitEdge), 4);
    tick();
    frames(29);
    chk("coinc29_hit", int'(monsterIsHit), 1);

    // Asynchronous reset mid-explosion
    #1 resetN = 1'b0;
    model_reset();
    #1;
    chk("areset_hit", int'(monsterIsHit), 0);
    chk("areset_dead", int'(monsterDead), 0);
    chk("areset_x", int'(topLeftX), 64);
    chk("areset_edge", int'(hitEdge), 0);
    chk("areset_pulse", int'(hitPulse), 0);
    tick();
    resetN = 1'b1;
    tick();
    frame();
    chk("post_reset_move", int'(topLeftX), 66);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
